word_ser: RTL and testbench

//  Word-to-byte stream serializer: accepts WORD_BITS-wide words on a valid/ready input stream and emits them as

---
 rtl/lwdo_stream_pkg.sv | 11 +
 rtl/word_ser.sv | 67 ++++++
 tb/tb_word_ser.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/lwdo_stream_pkg.sv
// Shared constants and helpers for the lwdo byte-stream blocks.
package lwdo_stream_pkg;

    localparam int BYTE_BITS = 8;

    // Width of a counter that must hold every value 0..n_bytes.
    function automatic int cnt_width(input int n_bytes);
        return $clog2(n_bytes + 1);
    endfunction

endpackage

// File: rtl/word_ser.sv
// word_ser: WORD_BITS-wide valid/ready words in, one 8-bit byte per clock out, no bubbles between words.
// Define WORD_SER_MSB_FIRST_EN for MSB-first byte order; the default build emits LSB first.
module word_ser
    import lwdo_stream_pkg::*;
#(
    parameter int WORD_BITS = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [WORD_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [7:0]           o_data,
    output logic                 o_valid,
    input  logic                 i_ready
);

    localparam int                N_BYTES = WORD_BITS / BYTE_BITS;
    localparam int                CNT_W   = cnt_width(N_BYTES);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(N_BYTES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [WORD_BITS-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 in_xfer;
    logic                 out_xfer;

    // o_ready looks at i_ready so the next word loads on the edge that sends the last byte.
    always_comb begin
        o_valid  = (cnt_q != '0);
        o_ready  = i_rst_n && ((cnt_q == '0) || ((cnt_q == CNT_ONE) && i_ready));
        in_xfer  = i_valid && o_ready;
        out_xfer = o_valid && i_ready;
`ifdef WORD_SER_MSB_FIRST_EN
        o_data   = sr_q[WORD_BITS-1 -: BYTE_BITS];
`else
        o_data   = sr_q[BYTE_BITS-1:0];
`endif
    end

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (in_xfer) begin
            sr_d  = i_data;
            cnt_d = CNT_FULL;
        end else if (out_xfer) begin
`ifdef WORD_SER_MSB_FIRST_EN
            sr_d  = sr_q << BYTE_BITS;
`else
            sr_d  = sr_q >> BYTE_BITS;
`endif
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_word_ser.sv
// Directed bench for word_ser (32-bit words); expected bytes follow WORD_SER_MSB_FIRST_EN when defined.
module tb_word_ser;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_ready;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int in_cnt = 0;

    logic [7:0] byte_q[$];
    int         cyc_q[$];
    bit         rdy_q[$];

    localparam logic [31:0] WORD_A = 32'hAABBCCDD;
    localparam logic [31:0] WORD_B = 32'h557799BC;

    word_ser #(.WORD_BITS(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change just after the rising edge, so the falling edge sees what the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            byte_q.push_back(o_data);
            cyc_q.push_back(cyc);
            rdy_q.push_back(o_ready);
        end
        if (rst_n && i_valid && o_ready) in_cnt <= in_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k);
`ifdef WORD_SER_MSB_FIRST_EN
        return w[31 - 8*k -: 8];
`else
        return w[8*k +: 8];
`endif
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        byte_q.delete();
        cyc_q.delete();
        rdy_q.delete();
    endtask

    // Present a word and return just after the edge that accepted it.
    task automatic send(input logic [31:0] w);
        bit acc;
        acc = 1'b0;
        i_data  = w;
        i_valid = 1'b1;
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 100 && byte_q.size() < n; i++) step(1);
        if (byte_q.size() < n) check_eq("byte_timeout", byte_q.size(), n);
    endtask

    task automatic check_word(input string tag, input logic [31:0] w, input int base);
        for (int k = 0; k < 4; k++) begin
            if (byte_q.size() > base + k)
                check_eq($sformatf("%s_b%0d", tag, k), {24'd0, byte_q[base+k]}, {24'd0, exp_byte(w, k)});
            else
                check_eq($sformatf("%s_b%0d_missing", tag, k), 32'd0, 32'd1);
        end
    endtask

    task automatic check_gapless(input string tag);
        for (int i = 1; i < cyc_q.size(); i++)
            check_eq($sformatf("%s_gap%0d", tag, i), cyc_q[i] - cyc_q[i-1], 32'd1);
    endtask

    initial begin
        int bad_hold;
        int in_snap;

        rst_n   = 1'b0;
        i_data  = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;

        // reset state, then idle
        step(3);
        check_eq("rst_valid", o_valid, 1'b0);
        check_eq("rst_ready", o_ready, 1'b0);
        check_eq("rst_data",  o_data,  8'h00);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_ready", o_ready, 1'b1);
        check_eq("post_rst_valid", o_valid, 1'b0);
        i_ready = 1'b1;
        step(5);
        check_eq("idle_no_bytes", byte_q.size(), 32'd0);
        check_eq("idle_valid", o_valid, 1'b0);

        // single word, sink always ready
        clear_q();
        send(WORD_A);
        wait_bytes(4);
        step(3);
        check_eq("single_count", byte_q.size(), 32'd4);
        check_word("single", WORD_A, 0);
        check_gapless("single");

        // back-to-back words
        clear_q();
        send(WORD_A);
        send(WORD_B);
        wait_bytes(8);
        step(3);
        check_eq("b2b_count", byte_q.size(), 32'd8);
        check_word("b2b_w0", WORD_A, 0);
        check_word("b2b_w1", WORD_B, 4);
        check_gapless("b2b");
        if (rdy_q.size() > 3) check_eq("b2b_ready_on_last", rdy_q[3], 1'b1);

        // input valid long before the sink is ready
        clear_q();
        i_ready = 1'b0;
        in_snap = in_cnt;
        send(WORD_A);
        i_valid = 1'b1;
        bad_hold = 0;
        for (int i = 0; i < 10; i++) begin
            if (!o_valid || o_data !== exp_byte(WORD_A, 0) || o_ready) bad_hold++;
            step(1);
        end
        check_eq("stall_hold", bad_hold, 32'd0);
        check_eq("stall_one_word", in_cnt - in_snap, 32'd1);
        i_valid = 1'b0;
        i_ready = 1'b1;
        wait_bytes(4);
        step(3);
        check_eq("stall_count", byte_q.size(), 32'd4);
        check_word("stall", WORD_A, 0);

        // sink toggling mid-word
        clear_q();
        i_ready = 1'b0;
        send(WORD_B);
        step(10);
        i_ready = 1'b1;
        step(2);
        i_ready = 1'b0;
        check_eq("toggle_partial", byte_q.size(), 32'd2);
        step(10);
        check_eq("toggle_held", byte_q.size(), 32'd2);
        i_ready = 1'b1;
        wait_bytes(4);
        step(3);
        check_eq("toggle_count", byte_q.size(), 32'd4);
        check_word("toggle", WORD_B, 0);

        // reset after two bytes of a word
        clear_q();
        send(WORD_A);
        step(2);
        check_eq("rstmid_sent", byte_q.size(), 32'd2);
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_valid", o_valid, 1'b0);
        check_eq("rstmid_ready", o_ready, 1'b0);
        check_eq("rstmid_data",  o_data,  8'h00);
        step(2);
        rst_n = 1'b1;
        #1;
        check_eq("rstmid_post_ready", o_ready, 1'b1);
        check_eq("rstmid_post_valid", o_valid, 1'b0);
        clear_q();
        send(WORD_B);
        wait_bytes(4);
        step(3);
        check_eq("rstmid_count", byte_q.size(), 32'd4);
        check_word("rstmid", WORD_B, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
